wm_load_arbiter: RTL and testbench

Mains-power budget arbiter for the washing machine loads: water valve, drain pump, drum motor and heater each request power, and the block grants only the subset whose summed weights fit the supply budget. It enforces fixed priority, staggered switch-on to limit inrush, and minimum on-time before preemption. It sits between the washing machine FSM's load-enable outputs and the actuator drivers; each actuator is driven by its grant bit.

---
 rtl/wm_load_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_wm_load_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_load_arbiter.sv
// Mains-power budget arbiter for washing machine loads: fixed priority, staggered switch-on,
// minimum on-time before preemption. Fault shedding is compiled in with WM_ARB_FAULT_SHED_EN.
module wm_load_arbiter #(
  parameter int BUDGET   = 8,
  parameter int W_VALVE  = 1,
  parameter int W_PUMP   = 1,
  parameter int W_MOTOR  = 3,
  parameter int W_HEATER = 6,
  parameter int MIN_ON   = 16,
  parameter int STAGGER  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       shed_fault,
  input  logic       fault_clr,
  output logic [3:0] grant,
  output logic [5:0] load_used,
  output logic       fault_latched
);
  localparam int TW = $clog2(MIN_ON + 1);
  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  localparam logic [TW-1:0] MIN_ON_T  = TW'(MIN_ON);
  localparam logic [CW-1:0] STAG_LOAD = CW'(STAGGER - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [5:0]    BUDGET_U  = 6'(BUDGET);
  // Loads heavier than the whole budget are never arbitrated.
  localparam logic [3:0]    SIZE_OK   = {W_HEATER <= BUDGET, W_MOTOR <= BUDGET,
                                         W_PUMP <= BUDGET, W_VALVE <= BUDGET};

  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_t;

  function automatic logic [5:0] weight_of(input logic [1:0] idx);
    case (idx)
      2'd0:    weight_of = 6'(W_VALVE);
      2'd1:    weight_of = 6'(W_PUMP);
      2'd2:    weight_of = 6'(W_MOTOR);
      2'd3:    weight_of = 6'(W_HEATER);
      default: weight_of = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] weight_sum(input logic [3:0] mask);
    logic [5:0] acc;
    acc = 6'd0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + (mask[i] ? weight_of(2'(i)) : 6'd0);
    end
    return acc;
  endfunction

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [TW-1:0] timer_r [4];

  logic [3:0] kept_s, pend_s, elig_s, victim_s, p_onehot_s, grant_run_s;
  logic [5:0] used_kept_s, used_run_s, free_s, p_w_s, elig_w_s;
  logic [1:0] p_idx_s;
  logic       p_valid_s, fits_s, preempt_s;

  // Arbitration decision for RUN: at most one new grant or one revocation per cycle.
  always_comb begin
    kept_s      = grant & req;
    used_kept_s = weight_sum(kept_s);
    free_s      = BUDGET_U - used_kept_s;
    pend_s      = req & ~grant & SIZE_OK;
    p_valid_s   = 1'b0;
    p_idx_s     = 2'd0;
    casez (pend_s)
      4'b???1: begin p_valid_s = 1'b1; p_idx_s = 2'd0; end
      4'b??10: begin p_valid_s = 1'b1; p_idx_s = 2'd1; end
      4'b?100: begin p_valid_s = 1'b1; p_idx_s = 2'd2; end
      4'b1000: begin p_valid_s = 1'b1; p_idx_s = 2'd3; end
      default: begin p_valid_s = 1'b0; p_idx_s = 2'd0; end
    endcase
    p_w_s      = weight_of(p_idx_s);
    p_onehot_s = p_valid_s ? (4'b0001 << p_idx_s) : 4'b0000;

    elig_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = kept_s[i] && (2'(i) > p_idx_s) && (timer_r[i] == MIN_ON_T);
    end
    elig_w_s = weight_sum(elig_s);
    victim_s = 4'b0000;
    casez (elig_s)
      4'b1???: victim_s = 4'b1000;
      4'b01??: victim_s = 4'b0100;
      4'b001?: victim_s = 4'b0010;
      4'b0001: victim_s = 4'b0001;
      default: victim_s = 4'b0000;
    endcase

    fits_s    = p_valid_s && (p_w_s <= free_s);
    preempt_s = p_valid_s && !fits_s && (|elig_s) &&
                (({1'b0, free_s} + {1'b0, elig_w_s}) >= {1'b0, p_w_s});
    if (fits_s) begin
      grant_run_s = kept_s | p_onehot_s;
    end else if (preempt_s) begin
      grant_run_s = kept_s & ~victim_s;
    end else begin
      grant_run_s = kept_s;
    end
    used_run_s = weight_sum(grant_run_s);
  end

`ifdef WM_ARB_FAULT_SHED_EN
  logic fault_r;
  assign fault_latched = fault_r;
`else
  logic unused_fault_s;
  assign unused_fault_s = shed_fault ^ fault_clr;
  assign fault_latched  = 1'b0;
`endif

  // Control FSM with registered grant/load_used; fault shedding overrides every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= RUN;
      cnt_r     <= {CW{1'b0}};
      grant     <= 4'b0000;
      load_used <= 6'd0;
`ifdef WM_ARB_FAULT_SHED_EN
      fault_r   <= 1'b0;
    end else if (shed_fault) begin
      state_r   <= FAULT;
      cnt_r     <= {CW{1'b0}};
      grant     <= 4'b0000;
      load_used <= 6'd0;
      fault_r   <= 1'b1;
`endif
    end else begin
      case (state_r)
        RUN: begin
          grant     <= grant_run_s;
          load_used <= used_run_s;
          if (fits_s) begin
            state_r <= HOLD;
            cnt_r   <= STAG_LOAD;
          end else begin
            state_r <= RUN;
            cnt_r   <= cnt_r;
          end
        end
        HOLD: begin
          grant     <= kept_s;
          load_used <= used_kept_s;
          if (cnt_r <= CNT_ONE) begin
            state_r <= RUN;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r <= HOLD;
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        FAULT: begin
          grant     <= 4'b0000;
          load_used <= 6'd0;
          cnt_r     <= {CW{1'b0}};
`ifdef WM_ARB_FAULT_SHED_EN
          if (fault_clr) begin
            state_r <= RUN;
            fault_r <= 1'b0;
          end else begin
            state_r <= FAULT;
            fault_r <= 1'b1;
          end
`else
          state_r   <= RUN;
`endif
        end
        default: begin
          state_r   <= RUN;
          cnt_r     <= {CW{1'b0}};
          grant     <= 4'b0000;
          load_used <= 6'd0;
        end
      endcase
    end
  end

  // Per-load on-timers: count held cycles, saturate at MIN_ON, clear while not granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        timer_r[i] <= {TW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!grant[i]) begin
          timer_r[i] <= {TW{1'b0}};
        end else if (timer_r[i] != MIN_ON_T) begin
          timer_r[i] <= timer_r[i] + TW'(1);
        end else begin
          timer_r[i] <= timer_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_wm_load_arbiter.sv
// Self-checking bench for wm_load_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model of the arbitration rules.
module tb_wm_load_arbiter;
  localparam int BUDGET  = 8;
  localparam int MIN_ON  = 16;
  localparam int STAGGER = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       shed_fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] grant;
  logic [5:0] load_used;
  logic       fault_latched;

  logic [3:0] req_ov = 4'b1001;
  logic       shed_ov = 1'b0;
  logic       clr_ov = 1'b0;
  logic [3:0] grant_ov;
  logic [5:0] used_ov;
  logic       flt_ov;

  int n_checks = 0;
  int n_errors = 0;

  int         wt [4] = '{1, 1, 3, 6};
  logic [3:0] m_grant;
  int         m_on [4];
  bit         m_fault, m_flt;
  int         m_edge, m_last;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [5:0] used;
  } vec_t;
  vec_t stagger_tbl [10];

  always #5 clk = ~clk;

  wm_load_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .shed_fault(shed_fault), .fault_clr(fault_clr),
    .grant(grant), .load_used(load_used), .fault_latched(fault_latched)
  );

  wm_load_arbiter #(.W_HEATER(9)) dut_ov (
    .clk(clk), .reset_n(reset_n), .req(req_ov), .shed_fault(shed_ov), .fault_clr(clr_ov),
    .grant(grant_ov), .load_used(used_ov), .fault_latched(flt_ov)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wsum(input logic [3:0] m);
    int s = 0;
    for (int i = 0; i < 4; i++) if (m[i]) s += wt[i];
    return s;
  endfunction

  task automatic model_reset();
    m_grant = 4'b0000;
    for (int i = 0; i < 4; i++) m_on[i] = 0;
    m_fault = 1'b0;
    m_flt   = 1'b0;
    m_edge  = 0;
    m_last  = -STAGGER;
  endtask

  // One clock edge of the arbitration rules, using the inputs present at that edge.
  task automatic model_edge();
    logic [3:0] kept, nxt;
    int p, vic, free, ew;
    bit in_fault;
    m_edge++;
    nxt = 4'b0000;
    in_fault = 1'b0;
`ifdef WM_ARB_FAULT_SHED_EN
    if (shed_fault) begin
      m_fault = 1'b1; m_flt = 1'b1; in_fault = 1'b1;
    end else if (m_fault) begin
      in_fault = 1'b1;
      if (fault_clr) begin
        m_fault = 1'b0; m_flt = 1'b0; m_last = m_edge - STAGGER + 1;
      end
    end
`endif
    if (!in_fault) begin
      kept = m_grant & req;
      nxt  = kept;
      if (m_edge - m_last >= STAGGER) begin
        p = -1;
        for (int i = 3; i >= 0; i--) if (req[i] && !m_grant[i] && wt[i] <= BUDGET) p = i;
        if (p >= 0) begin
          free = BUDGET - wsum(kept);
          if (wt[p] <= free) begin
            nxt[p] = 1'b1;
            m_last = m_edge;
          end else begin
            ew = 0; vic = -1;
            for (int i = p + 1; i < 4; i++) begin
              if (kept[i] && m_on[i] >= MIN_ON) begin ew += wt[i]; vic = i; end
            end
            if (vic >= 0 && free + ew >= wt[p]) nxt[vic] = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (nxt[i] && m_grant[i]) m_on[i] = (m_on[i] >= MIN_ON) ? MIN_ON : m_on[i] + 1;
      else m_on[i] = 0;
    end
    m_grant = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_grant", grant, m_grant);
    chk("model_used", load_used, wsum(m_grant));
    chk("model_fault", fault_latched, m_flt);
  endtask

  task automatic do_reset();
    req = 4'b0000; shed_fault = 1'b0; fault_clr = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    stagger_tbl = '{
      '{4'b0111, 4'b0001, 6'd1}, '{4'b0111, 4'b0001, 6'd1},
      '{4'b0111, 4'b0001, 6'd1}, '{4'b0111, 4'b0001, 6'd1},
      '{4'b0111, 4'b0011, 6'd2}, '{4'b0111, 4'b0011, 6'd2},
      '{4'b0111, 4'b0011, 6'd2}, '{4'b0111, 4'b0011, 6'd2},
      '{4'b0111, 4'b0111, 6'd5}, '{4'b0111, 4'b0111, 6'd5}
    };

    // Reset state
    @(posedge clk);
    #1;
    chk("reset_grant", grant, 4'b0000);
    chk("reset_used", load_used, 6'd0);
    chk("reset_fault", fault_latched, 1'b0);
    do_reset();

    // Stagger table from reset
    for (int i = 0; i < 10; i++) begin
      req = stagger_tbl[i].req;
      step();
      chk("stagger_grant", grant, stagger_tbl[i].grant);
      chk("stagger_used", load_used, stagger_tbl[i].used);
    end

    // Budget blocking, then release frees room for the heater
    repeat (3) step();
    req = 4'b1111;
    repeat (5) step();
    chk("budget_block", grant, 4'b0111);
    req = 4'b1011;
    step();
    chk("budget_release_grant", grant, 4'b1011);
    chk("budget_release_used", load_used, 6'd8);

    // Preemption of a long-running heater
    do_reset();
    req = 4'b1000;
    repeat (21) step();
    chk("preempt_heater_on", grant, 4'b1000);
    req = 4'b1100;
    step();
    chk("preempt_revoke", grant, 4'b0000);
    step();
    chk("preempt_motor", grant, 4'b0100);
    chk("preempt_motor_used", load_used, 6'd3);
    repeat (4) step();
    chk("preempt_settled", grant, 4'b0100);

    // Heater on only 5 cycles: revocation waits for the on-timer
    do_reset();
    req = 4'b1000;
    repeat (5) step();
    req = 4'b1100;
    for (int e = 6; e <= 17; e++) begin
      step();
      chk("min_on_hold", grant, 4'b1000);
    end
    step();
    chk("min_on_revoke", grant, 4'b0000);
    step();
    chk("min_on_motor", grant, 4'b0100);

    // Oversize heater on the second instance
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step();
      chk("oversize_grant", grant_ov, 4'b0001);
      chk("oversize_used", used_ov, 6'd1);
    end

    // Fault shedding
    do_reset();
    req = 4'b0111;
    repeat (9) step();
    chk("fault_pre", grant, 4'b0111);
    shed_fault = 1'b1;
    step();
`ifdef WM_ARB_FAULT_SHED_EN
    chk("fault_shed_grant", grant, 4'b0000);
    chk("fault_shed_used", load_used, 6'd0);
    chk("fault_shed_latch", fault_latched, 1'b1);
    fault_clr = 1'b1;
    step();
    chk("fault_clr_ignored", fault_latched, 1'b1);
    shed_fault = 1'b0; fault_clr = 1'b0;
    step();
    chk("fault_held_grant", grant, 4'b0000);
    fault_clr = 1'b1;
    step();
    chk("fault_cleared", fault_latched, 1'b0);
    chk("fault_cleared_grant", grant, 4'b0000);
    fault_clr = 1'b0;
    step();
    chk("fault_first_grant", grant, 4'b0001);
`else
    chk("noflt_grant", grant, 4'b0111);
    chk("noflt_latch", fault_latched, 1'b0);
    shed_fault = 1'b0; fault_clr = 1'b1;
    step();
    chk("noflt_clr", grant, 4'b0111);
    fault_clr = 1'b0;
`endif

    // Asynchronous reset in HOLD
    do_reset();
    req = 4'b0001;
    repeat (2) step();
    chk("async_pre", grant, 4'b0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", grant, 4'b0000);
    chk("async_used", load_used, 6'd0);
    chk("async_fault", fault_latched, 1'b0);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      shed_fault = ($urandom_range(0, 119) == 0);
      fault_clr  = ($urandom_range(0, 11) == 0);
      step();
      if (load_used > 6'(BUDGET)) chk("budget_cap", load_used, BUDGET);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
